// File: rtl/srt_div_pkg.sv
// Shared types and constants for the SRT divider request scheduler.
// Optional divide-by-zero bypass is enabled with the SRT_SCHED_DIVZERO_EN macro.
package srt_div_pkg;

    localparam int DEF_W = 64;

    // One-hot state encoding.
    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_ISSUE   = 5'b00010,
        ST_WAIT_LO = 5'b00100,
        ST_WAIT_HI = 5'b01000,
        ST_RESP    = 5'b10000
    } state_t;

    localparam logic [DEF_W-1:0] DZ_QUO = {DEF_W{1'b1}};

endpackage

// File: rtl/srt_div_sched_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr_i, searching cyclically.
// The pointer register lives in the caller.
module rr_arb #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    input  logic           en_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] gnt_idx_o
);

    always_comb begin
        logic           w_found;
        logic [IDW-1:0] w_idx;
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        gnt_o     = '0;
        gnt_idx_o = '0;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = IDW'((int'(ptr_i) + k) % N);
            if (en_i && !w_found && req_i[w_idx]) begin
                w_found      = 1'b1;
                gnt_o[w_idx] = 1'b1;
                gnt_idx_o    = w_idx;
            end
        end
    end

endmodule

// File: rtl/srt_div_sched.sv
// Shares one radix-4 SRT divider between NREQ requesters with round-robin arbitration.
// Define SRT_SCHED_DIVZERO_EN to answer zero-divisor requests locally without the divider.
module srt_div_sched
    import srt_div_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = DEF_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_vld_i,
    input  logic [NREQ*W-1:0] req_op1_i,
    input  logic [NREQ*W-1:0] req_op2_i,
    output logic [NREQ-1:0]   req_rdy_o,
    output logic              rsp_vld_o,
    output logic [IDW-1:0]    rsp_id_o,
    output logic [W-1:0]      rsp_quo_o,
    output logic [W-1:0]      rsp_rem_o,
    output logic              rsp_dz_o,
    input  logic              rsp_rdy_i,
    output logic              div_vld_o,
    output logic [W-1:0]      div_op1_o,
    output logic [W-1:0]      div_op2_o,
    input  logic              div_ready_i,
    input  logic [W-1:0]      div_quo_i,
    input  logic [W-1:0]      div_rem_i
);

    state_t         r_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic [W-1:0]   r_op1;
    logic [W-1:0]   r_op2;
    logic           r_rsp_vld;
    logic [W-1:0]   r_rsp_quo;
    logic [W-1:0]   r_rsp_rem;

    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_idx;
    logic            w_gnt_any;
    logic            w_arb_en;
    logic [W-1:0]    w_sel_op1;
    logic [W-1:0]    w_sel_op2;
    logic [IDW-1:0]  w_ptr_nxt;

    // Reset is folded in so no accept pulse can escape while the FSM is held.
    assign w_arb_en  = (r_state == ST_IDLE) && div_ready_i && !rst;
    assign w_gnt_any = |w_gnt;
    assign w_sel_op1 = req_op1_i[w_gnt_idx*W +: W];
    assign w_sel_op2 = req_op2_i[w_gnt_idx*W +: W];
    assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);

    rr_arb #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_arb (
        .req_i     (req_vld_i),
        .ptr_i     (r_ptr),
        .en_i      (w_arb_en),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_gnt_idx)
    );

    assign req_rdy_o = w_gnt;
    assign div_vld_o = (r_state == ST_ISSUE);
    assign div_op1_o = r_op1;
    assign div_op2_o = r_op2;
    assign rsp_vld_o = r_rsp_vld;
    assign rsp_id_o  = r_id;
    assign rsp_quo_o = r_rsp_quo;
    assign rsp_rem_o = r_rsp_rem;

`ifdef SRT_SCHED_DIVZERO_EN
    logic r_rsp_dz;
    assign rsp_dz_o = r_rsp_dz;
`else
    assign rsp_dz_o = 1'b0;
`endif

    // NOTE: all state and datapath registers are updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_id      <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_rsp_vld <= 1'b0;
            r_rsp_quo <= '0;
            r_rsp_rem <= '0;
`ifdef SRT_SCHED_DIVZERO_EN
            r_rsp_dz  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_any) begin
                        r_ptr <= w_ptr_nxt;
                        r_id  <= w_gnt_idx;
                        r_op1 <= w_sel_op1;
                        r_op2 <= w_sel_op2;
`ifdef SRT_SCHED_DIVZERO_EN
                        if (w_sel_op2 == '0) begin
                            r_rsp_vld <= 1'b1;
                            r_rsp_quo <= DZ_QUO[W-1:0];
                            r_rsp_rem <= w_sel_op1;
                            r_rsp_dz  <= 1'b1;
                            r_state   <= ST_RESP;
                        end else begin
                            r_rsp_dz  <= 1'b0;
                            r_state   <= ST_ISSUE;
                        end
`else
                        r_state <= ST_ISSUE;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (div_ready_i) r_state <= ST_WAIT_LO;
                end
                ST_WAIT_LO: begin
                    if (!div_ready_i) r_state <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (div_ready_i) begin
                        r_rsp_quo <= div_quo_i;
                        r_rsp_rem <= div_rem_i;
                        r_rsp_vld <= 1'b1;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_rdy_i) begin
                        r_rsp_vld <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_srt_div_sched.sv
// Randomised self-checking bench for srt_div_sched with a behavioural divider and scoreboard.
// Honours SRT_SCHED_DIVZERO_EN when the same macro is defined for the build.
module tb_srt_div_sched;

    localparam int NREQ = 4;
    localparam int W    = 64;
    localparam int IDW  = 2;
`ifdef SRT_SCHED_DIVZERO_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_vld_i;
    logic [NREQ*W-1:0] req_op1_i;
    logic [NREQ*W-1:0] req_op2_i;
    logic [NREQ-1:0]   req_rdy_o;
    logic              rsp_vld_o;
    logic [IDW-1:0]    rsp_id_o;
    logic [W-1:0]      rsp_quo_o;
    logic [W-1:0]      rsp_rem_o;
    logic              rsp_dz_o;
    logic              rsp_rdy_i;
    logic              div_vld_o;
    logic [W-1:0]      div_op1_o;
    logic [W-1:0]      div_op2_o;
    logic              div_ready_i;
    logic [W-1:0]      div_quo_i;
    logic [W-1:0]      div_rem_i;

    srt_div_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_vld_i(req_vld_i), .req_op1_i(req_op1_i), .req_op2_i(req_op2_i), .req_rdy_o(req_rdy_o),
        .rsp_vld_o(rsp_vld_o), .rsp_id_o(rsp_id_o), .rsp_quo_o(rsp_quo_o), .rsp_rem_o(rsp_rem_o),
        .rsp_dz_o(rsp_dz_o), .rsp_rdy_i(rsp_rdy_i),
        .div_vld_o(div_vld_o), .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
        .div_ready_i(div_ready_i), .div_quo_i(div_quo_i), .div_rem_i(div_rem_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Signed truncating division; a zero divisor yields all-ones and the dividend.
    function automatic logic [127:0] ref_div(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] q, r;
        if (b == 64'd0) return {64'hFFFF_FFFF_FFFF_FFFF, a};
        q = 64'($signed(a) / $signed(b));
        r = 64'($signed(a) % $signed(b));
        return {q, r};
    endfunction

    // Behavioural divider: ready when idle, busy for a random number of cycles after sampling.
    logic        d_rdy;
    int          d_cnt;
    logic [63:0] d_pq, d_pr;
    int          lat_lo = 0;
    int          lat_hi = 6;
    assign div_ready_i = d_rdy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d_rdy     <= 1'b1;
            d_cnt     <= 0;
            div_quo_i <= 64'h5A5A_5A5A_5A5A_5A5A;
            div_rem_i <= 64'hA5A5_A5A5_A5A5_A5A5;
        end else if (d_rdy && div_vld_o) begin
            d_rdy        <= 1'b0;
            d_cnt        <= int'($urandom_range(lat_hi, lat_lo));
            {d_pq, d_pr} <= ref_div(div_op1_o, div_op2_o);
        end else if (!d_rdy) begin
            if (d_cnt == 0) begin
                d_rdy     <= 1'b1;
                div_quo_i <= d_pq;
                div_rem_i <= d_pr;
            end else begin
                d_cnt <= d_cnt - 1;
            end
        end
    end

    typedef struct {
        logic [1:0]  id;
        logic [63:0] op1, op2, quo, rem;
        logic        dz, byp;
        int          gcyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [127:0] q[NREQ][$];
    logic        m_busy    = 1'b0;
    int          m_ptr     = 0;
    logic        m_sampled = 1'b0;
    int          m_lat     = 0;
    logic        prev_hold = 1'b0;
    logic [3:0]  acc_r     = '0;
    bit          drop_en   = 1'b0;
    int          rdy_mode  = 1;

    int          gnt_log[$];
    int          id_log[$];
    logic [63:0] quo_log[$];
    logic [63:0] rem_log[$];
    logic        dz_log[$];
    logic        samp_log[$];
    int          lat_log[$];

    // Compare process: scoreboard checked on every falling edge outside reset.
    always @(negedge clk) begin : mon
        logic [3:0] acc, exp_acc;
        int         win;
        exp_t       e;
        if (!rst) begin
            acc = req_vld_i & req_rdy_o;
            if (m_busy) check("rdy_only_when_idle", 128'(req_rdy_o), 128'd0);
            win = -1;
            for (int k = 0; k < NREQ; k++)
                if (win < 0 && req_vld_i[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
            exp_acc = (!m_busy && div_ready_i && win >= 0) ? 4'(1 << win) : 4'd0;
            if (acc != 0 || exp_acc != 0) begin
                check("grant", 128'(acc), 128'(exp_acc));
                if (exp_acc != 0) begin
                    e.id  = 2'(win);
                    e.op1 = req_op1_i[win*W +: W];
                    e.op2 = req_op2_i[win*W +: W];
                    {e.quo, e.rem} = ref_div(e.op1, e.op2);
                    e.byp  = DZ_EN && (e.op2 == 64'd0);
                    e.dz   = e.byp;
                    e.gcyc = cyc;
                    exp_q.push_back(e);
                    m_busy    = 1'b1;
                    m_sampled = 1'b0;
                    m_ptr     = (win + 1) % NREQ;
                    gnt_log.push_back(win);
                end
            end
            acc_r = acc;

            if (div_vld_o && div_ready_i) begin
                if (exp_q.size() == 0) check("issue_spurious", 128'd1, 128'd0);
                else begin
                    e = exp_q[0];
                    check("issue_ops", {div_op1_o, div_op2_o}, {e.op1, e.op2});
                    check("issue_once", 128'(m_sampled), 128'd0);
                    check("issue_not_bypassed", 128'(e.byp), 128'd0);
                    m_sampled = 1'b1;
                end
            end

            if (rsp_vld_o) begin
                check("no_issue_in_resp", 128'(div_vld_o), 128'd0);
                if (exp_q.size() == 0) check("rsp_spurious", 128'd1, 128'd0);
                else begin
                    e = exp_q[0];
                    check("rsp_id", 128'(rsp_id_o), 128'(e.id));
                    check("rsp_quo", 128'(rsp_quo_o), 128'(e.quo));
                    check("rsp_rem", 128'(rsp_rem_o), 128'(e.rem));
                    check("rsp_dz", 128'(rsp_dz_o), 128'(e.dz));
                    if (!prev_hold) m_lat = cyc - e.gcyc;
                    if (!e.byp) check("rsp_used_divider", 128'(m_sampled), 128'd1);
                    if (rsp_rdy_i) begin
                        void'(exp_q.pop_front());
                        m_busy = 1'b0;
                        id_log.push_back(int'(rsp_id_o));
                        quo_log.push_back(rsp_quo_o);
                        rem_log.push_back(rsp_rem_o);
                        dz_log.push_back(rsp_dz_o);
                        samp_log.push_back(m_sampled);
                        lat_log.push_back(m_lat);
                    end
                end
            end
            prev_hold = rsp_vld_o && !rsp_rdy_i;
        end
    end

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (q[i].size() > 0) begin
                req_vld_i[i] = !drop_en || ($urandom_range(3, 0) != 0);
                {req_op1_i[i*W +: W], req_op2_i[i*W +: W]} = q[i][0];
            end else begin
                req_vld_i[i] = 1'b0;
                req_op1_i[i*W +: W] = '0;
                req_op2_i[i*W +: W] = '0;
            end
        end
        rsp_rdy_i = (rdy_mode == 2) ? 1'($urandom_range(1, 0)) : (rdy_mode == 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (acc_r[i] && q[i].size() > 0) void'(q[i].pop_front());
        acc_r = '0;
        drive();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) if (q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_done(input int maxc);
        int n = 0;
        while ((!all_empty() || m_busy) && n < maxc) begin
            step();
            n++;
        end
        if (n >= maxc) check("timeout_run_done", 128'd1, 128'd0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) q[i].delete();
        m_busy    = 1'b0;
        m_ptr     = 0;
        m_sampled = 1'b0;
        prev_hold = 1'b0;
        acc_r     = '0;
        req_vld_i = '0;
    endtask

    task automatic clear_logs();
        gnt_log.delete(); id_log.delete(); quo_log.delete(); rem_log.delete();
        dz_log.delete(); samp_log.delete(); lat_log.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_model();
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic expect_rsp(input int k, input int id, input logic [63:0] quo, input logic [63:0] rem);
        if (k < quo_log.size()) begin
            check("log_id", 128'(id_log[k]), 128'(id));
            check("log_quo", 128'(quo_log[k]), 128'(quo));
            check("log_rem", 128'(rem_log[k]), 128'(rem));
        end else check("log_rsp_count", 128'(quo_log.size()), 128'(k + 1));
    endtask

    task automatic expect_gnt(input int k, input int id);
        if (k < gnt_log.size()) check("log_grant", 128'(gnt_log[k]), 128'(id));
        else check("log_grant_count", 128'(gnt_log.size()), 128'(k + 1));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_rdy"}, 128'(req_rdy_o), 128'd0);
        check({tag, "_rsp_vld"}, 128'(rsp_vld_o), 128'd0);
        check({tag, "_rsp_id"}, 128'(rsp_id_o), 128'd0);
        check({tag, "_rsp_quo_rem"}, {rsp_quo_o, rsp_rem_o}, 128'd0);
        check({tag, "_rsp_dz"}, 128'(rsp_dz_o), 128'd0);
        check({tag, "_div_vld"}, 128'(div_vld_o), 128'd0);
        check({tag, "_div_ops"}, {div_op1_o, div_op2_o}, 128'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, got cycle %0d expected under 90000", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        logic [63:0] a, b, s_quo, s_rem;
        logic [1:0]  s_id;
        int          n;
        rst = 1'b1;
        req_vld_i = '0; req_op1_i = '0; req_op2_i = '0; rsp_rdy_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Single request 100/7 from requester 0.
        clear_logs();
        q[0].push_back({64'd100, 64'd7});
        run_done(200);
        check("single_grant_count", 128'(gnt_log.size()), 128'd1);
        expect_gnt(0, 0);
        expect_rsp(0, 0, 64'd14, 64'd2);

        // All four at once from ptr=0.
        do_reset();
        clear_logs();
        q[0].push_back({64'd40, 64'd4});
        q[1].push_back({64'd41, 64'd5});
        q[2].push_back({64'd42, 64'd6});
        q[3].push_back({64'd43, 64'd7});
        run_done(400);
        for (int k = 0; k < 4; k++) expect_gnt(k, k);
        expect_rsp(0, 0, 64'd10, 64'd0);
        expect_rsp(1, 1, 64'd8, 64'd1);
        expect_rsp(2, 2, 64'd7, 64'd0);
        expect_rsp(3, 3, 64'd6, 64'd1);

        // Response backpressure for 20 cycles with other requesters waiting.
        clear_logs();
        rdy_mode = 0;
        q[2].push_back({64'd1000, 64'd3});
        n = 0;
        while (!rsp_vld_o && n < 100) begin step(); n++; end
        if (n >= 100) check("timeout_bp_rsp", 128'd1, 128'd0);
        q[0].push_back({64'd9, 64'd2});
        q[1].push_back({64'd8, 64'd3});
        s_id = rsp_id_o; s_quo = rsp_quo_o; s_rem = rsp_rem_o;
        repeat (20) step();
        check("bp_still_valid", 128'(rsp_vld_o), 128'd1);
        check("bp_id_stable", 128'(rsp_id_o), 128'(s_id));
        check("bp_data_stable", {rsp_quo_o, rsp_rem_o}, {s_quo, s_rem});
        check("bp_no_new_grant", 128'(gnt_log.size()), 128'd1);
        rdy_mode = 1;
        run_done(400);
        expect_rsp(0, 2, 64'd333, 64'd1);
        expect_rsp(1, 0, 64'd4, 64'd1);
        expect_rsp(2, 1, 64'd2, 64'd2);

        // Fairness between requesters 1 and 3 from ptr=0.
        do_reset();
        clear_logs();
        for (int k = 0; k < 4; k++) begin
            q[1].push_back({64'(20 + k), 64'd3});
            q[3].push_back({64'(30 + k), 64'd4});
        end
        run_done(600);
        for (int k = 0; k < 8; k++) expect_gnt(k, (k % 2 == 0) ? 1 : 3);

        // Divide by zero.
        clear_logs();
        q[0].push_back({64'd55, 64'd0});
        run_done(200);
        expect_rsp(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd55);
        if (dz_log.size() > 0) begin
            check("dz_flag", 128'(dz_log[0]), 128'(DZ_EN));
            check("dz_reached_divider", 128'(samp_log[0]), 128'(!DZ_EN));
            check("dz_fast_response", 128'(lat_log[0] <= 2), 128'(DZ_EN));
        end else check("dz_rsp_count", 128'd0, 128'd1);

        // Reset while waiting for the divider result.
        clear_logs();
        lat_lo = 20; lat_hi = 20;
        q[0].push_back({64'd77, 64'd5});
        n = 0;
        while (div_ready_i && n < 50) begin step(); n++; end
        if (n >= 50) check("timeout_wait_busy", 128'd1, 128'd0);
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("midop_reset");
        clear_model();
        repeat (2) step();
        rst = 1'b0;
        lat_lo = 0; lat_hi = 6;
        q[0].push_back({64'd9, 64'd3});
        run_done(200);
        check("midop_one_rsp", 128'(quo_log.size()), 128'd1);
        expect_rsp(0, 0, 64'd3, 64'd0);

        // Random traffic with drops, backpressure and random divider latency.
        drop_en  = 1'b1;
        rdy_mode = 2;
        for (int k = 0; k < 300; k++) begin
            a = {$urandom, $urandom};
            case ($urandom_range(7, 0))
                0:       b = 64'd0;
                1, 2:    b = {$urandom, $urandom};
                default: b = 64'($signed(32'($urandom_range(2000, 0))) - 1000);
            endcase
            if (b == 64'd0 && $urandom_range(1, 0) == 1) b = 64'd1;
            if (a == 64'h8000_0000_0000_0000 && b == '1) a = 64'd1;
            if (k % 5 == 0) a = 64'($urandom_range(5000, 0));
            q[$urandom_range(NREQ - 1, 0)].push_back({a, b});
        end
        run_done(30000);
        drop_en  = 1'b0;
        rdy_mode = 1;
        check("final_scoreboard_empty", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
